// File: rtl/histeq_pkg.sv
// -----------------------------------------------------------------------------
// histeq_pkg
// Shared definitions for the histogram-equalization IP. The frame controller
// and the CDF/LUT datapath both import this package.
//   state_t      : frame sequencer states
//   PIXEL_SIZE   : default pixel width
//   NUM_BINS     : default histogram bin count (2**PIXEL_SIZE)
//   FRAME_PIXELS : default pixels per frame (640x480)
// -----------------------------------------------------------------------------
package histeq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      CDF,
      DONE
   } state_t;

   localparam int PIXEL_SIZE   = 8;
   localparam int NUM_BINS     = 2 ** PIXEL_SIZE;
   localparam int FRAME_PIXELS = 640 * 480;

endpackage

// File: rtl/histeq_delay_line.sv
// -----------------------------------------------------------------------------
// histeq_delay_line
// Depth-stage shift register for the {enable, address} pair. It turns the
// histogram read strobe into the LUT write strobe once the CDF pipeline has
// produced the matching value.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low reset
//   rd_en    : histogram read enable entering the pipeline
//   rd_addr  : histogram read address entering the pipeline
//   wr_en    : LUT write enable, rd_en delayed Depth cycles
//   wr_addr  : LUT write address, rd_addr delayed Depth cycles
// -----------------------------------------------------------------------------
module histeq_delay_line #(
   parameter int Depth = 2,
   parameter int Width = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_en,
   input  logic [Width-1:0] rd_addr,
   output logic             wr_en,
   output logic [Width-1:0] wr_addr
);

   logic             en_q   [Depth];
   logic [Width-1:0] addr_q [Depth];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: every stage is reset, not just the enables, so an aborted
         // frame can never leak a stale address out on the next frame.
         for (int i = 0; i < Depth; i++) begin
            en_q[i]   <= 1'b0;
            addr_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous
         // stage's old value, which is what makes this a shift register.
         en_q[0]   <= rd_en;
         addr_q[0] <= rd_addr;
         for (int i = 1; i < Depth; i++) begin
            en_q[i]   <= en_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   assign wr_en   = en_q[Depth-1];
   assign wr_addr = addr_q[Depth-1];

endmodule

// File: rtl/histeq_frame_ctrl.sv
// -----------------------------------------------------------------------------
// histeq_frame_ctrl
// Frame-level sequencer for the histogram-equalization IP. One frame runs
// CLEAR -> ACCUM -> CDF -> DONE:
//   CLEAR : writes every histogram bin to zero and holds the min-count unit
//           in reset
//   ACCUM : accepts exactly one frame of pixels
//   CDF   : reads every bin for the CDF accumulator and drains the pipeline
//   DONE  : pulses done once the last LUT entry has been written
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   start                      : begin a frame (sampled in IDLE only)
//   pix_valid / pix_ready      : pixel handshake (ready only in ACCUM)
//   hist_clr_en/hist_clr_addr  : histogram RAM clear write
//   hist_acc_en                : increment the bin of the accepted pixel
//   min_reset, min_valid       : min-count unit control
//   min_histo                  : count of the minimum pixel value
//   cdf_rd_en/cdf_rd_addr      : histogram read for the CDF
//   cdf_acc_clr                : clear the CDF accumulator (first read)
//   lut_wr_en/lut_wr_addr      : LUT write, trailing reads by RdLat cycles
//   lut_identity               : flat frame, LUT gets the identity mapping
//   pix_count                  : pixels accepted this frame
//   busy, done                 : frame in progress, one-cycle completion
// -----------------------------------------------------------------------------
module histeq_frame_ctrl
   import histeq_pkg::*;
#(
   parameter int PixelSize   = PIXEL_SIZE,
   parameter int FrameWidth  = 640,
   parameter int FrameHeight = 480,
   parameter int histoWidth  = $clog2(FrameWidth * FrameHeight),
   parameter int RdLat       = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   output logic                  hist_clr_en,
   output logic [PixelSize-1:0]  hist_clr_addr,
   output logic                  hist_acc_en,
   output logic                  min_reset,
   output logic                  min_valid,
   input  logic [histoWidth-1:0] min_histo,
   output logic                  cdf_rd_en,
   output logic [PixelSize-1:0]  cdf_rd_addr,
   output logic                  cdf_acc_clr,
   output logic                  lut_wr_en,
   output logic [PixelSize-1:0]  lut_wr_addr,
   output logic                  lut_identity,
   output logic [histoWidth-1:0] pix_count,
   output logic                  busy,
   output logic                  done
);

   localparam int NumBins = 2 ** PixelSize;
   localparam int NumPix  = FrameWidth * FrameHeight;
   // One counter walks the bins in CLEAR and the bins plus drain in CDF.
   localparam int CntW    = $clog2(NumBins + RdLat);

   localparam logic [CntW-1:0]       ClrLast  = CntW'(NumBins - 1);
   localparam logic [CntW-1:0]       BinsEnd  = CntW'(NumBins);
   localparam logic [CntW-1:0]       CdfLast  = CntW'(NumBins + RdLat - 1);
   localparam logic [histoWidth-1:0] PixTotal = histoWidth'(NumPix);
   localparam logic [histoWidth-1:0] PixLast  = histoWidth'(NumPix - 1);

   state_t          state;
   state_t          state_next;
   logic [CntW-1:0] cnt;
   logic            accept;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and Moore outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output gets a default before the case so no path through
      // the case leaves one unassigned and infers a latch.
      state_next    = state;
      pix_ready     = 1'b0;
      hist_clr_en   = 1'b0;
      hist_clr_addr = '0;
      min_reset     = 1'b0;
      cdf_rd_en     = 1'b0;
      cdf_rd_addr   = '0;
      cdf_acc_clr   = 1'b0;
      done          = 1'b0;

      case (state)
         IDLE: begin
            if (start) state_next = CLEAR;
         end
         CLEAR: begin
            hist_clr_en   = 1'b1;
            hist_clr_addr = cnt[PixelSize-1:0];
            min_reset     = 1'b1;
            if (cnt == ClrLast) state_next = ACCUM;
         end
         ACCUM: begin
            pix_ready = 1'b1;
            if (pix_valid && pix_count == PixLast) state_next = CDF;
         end
         CDF: begin
            // Reads occupy the first NumBins cycles; the rest drain the pipe.
            if (cnt < BinsEnd) begin
               cdf_rd_en   = 1'b1;
               cdf_rd_addr = cnt[PixelSize-1:0];
               cdf_acc_clr = (cnt == '0);
            end
            if (cnt == CdfLast) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept      = pix_valid & pix_ready;
   assign hist_acc_en = accept;
   assign min_valid   = accept;
   assign busy        = (state != IDLE);

   // ---------------------------------------------------------------------------
   // Counters and the flat-frame flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt          <= '0;
         pix_count    <= '0;
         lut_identity <= 1'b0;
      end else begin
         // Restarting on every state change keeps cnt from ever wrapping.
         if (state_next != state) begin
            cnt <= '0;
         end else if (state == CLEAR || state == CDF) begin
            cnt <= cnt + 1'b1;
         end

         if (state == IDLE && start) begin
            pix_count <= '0;
         end else if (accept && pix_count != PixTotal) begin
            pix_count <= pix_count + 1'b1;
         end

         // A frame of one value has min count == frame size; the CDF divisor
         // would be zero, so the LUT takes the identity mapping instead.
         if (state == ACCUM && state_next == CDF) begin
            lut_identity <= (min_histo == PixTotal);
         end else if (state == DONE) begin
            lut_identity <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // LUT write strobe trails the histogram read by the CDF pipeline latency
   // ---------------------------------------------------------------------------
   histeq_delay_line #(
      .Depth (RdLat),
      .Width (PixelSize)
   ) u_lut_delay (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (cdf_rd_en),
      .rd_addr (cdf_rd_addr),
      .wr_en   (lut_wr_en),
      .wr_addr (lut_wr_addr)
   );

endmodule

// File: tb/tb_histeq_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_histeq_frame_ctrl
// Directed bench for histeq_frame_ctrl on a reduced 20x10 frame (200 pixels)
// with 256 bins and RdLat = 2. Each task drives one scenario and compares
// outputs at the falling edge against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_histeq_frame_ctrl;

   localparam int PS = 8;
   localparam int FW = 20;
   localparam int FH = 10;
   localparam int N  = FW * FH;
   localparam int HW = $clog2(N);
   localparam int RL = 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic          pix_valid;
   logic          pix_ready;
   logic          hist_clr_en;
   logic [PS-1:0] hist_clr_addr;
   logic          hist_acc_en;
   logic          min_reset;
   logic          min_valid;
   logic [HW-1:0] min_histo;
   logic          cdf_rd_en;
   logic [PS-1:0] cdf_rd_addr;
   logic          cdf_acc_clr;
   logic          lut_wr_en;
   logic [PS-1:0] lut_wr_addr;
   logic          lut_identity;
   logic [HW-1:0] pix_count;
   logic          busy;
   logic          done;

   logic [42:0]   outs;

   int vectors     = 0;
   int miscompares = 0;

   histeq_frame_ctrl #(
      .PixelSize   (PS),
      .FrameWidth  (FW),
      .FrameHeight (FH),
      .histoWidth  (HW),
      .RdLat       (RL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .hist_clr_en   (hist_clr_en),
      .hist_clr_addr (hist_clr_addr),
      .hist_acc_en   (hist_acc_en),
      .min_reset     (min_reset),
      .min_valid     (min_valid),
      .min_histo     (min_histo),
      .cdf_rd_en     (cdf_rd_en),
      .cdf_rd_addr   (cdf_rd_addr),
      .cdf_acc_clr   (cdf_acc_clr),
      .lut_wr_en     (lut_wr_en),
      .lut_wr_addr   (lut_wr_addr),
      .lut_identity  (lut_identity),
      .pix_count     (pix_count),
      .busy          (busy),
      .done          (done)
   );

   assign outs = {pix_ready, hist_clr_en, hist_clr_addr, hist_acc_en, min_reset,
                  min_valid, cdf_rd_en, cdf_rd_addr, cdf_acc_clr, lut_wr_en,
                  lut_wr_addr, lut_identity, pix_count, busy, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reset drives every output low; released, the controller idles.
   task automatic test_reset();
      reset     = 1'b0;
      start     = 1'b0;
      pix_valid = 1'b0;
      min_histo = '0;
      #2;
      vectors++;
      if (outs !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want 0", outs);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({busy, pix_ready, hist_clr_en, done} !== 4'b0000) begin
         miscompares++;
         $display("FAIL idle_after_reset: got %b want 0000",
                  {busy, pix_ready, hist_clr_en, done});
      end
   endtask

   // Start from IDLE: 256 clear writes, min_reset high throughout, then ACCUM.
   task automatic test_clear(input bit noisy);
      start     = 1'b1;
      pix_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         pix_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         vectors++;
         if ({busy, hist_clr_en, hist_clr_addr, min_reset, pix_ready, hist_acc_en}
             !== {2'b11, 8'(i), 3'b100}) begin
            miscompares++;
            $display("FAIL clear_cycle %0d: got busy/en/addr/minrst/rdy/acc=%b/%b/%0d/%b/%b/%b want 1/1/%0d/1/0/0",
                     i, busy, hist_clr_en, hist_clr_addr, min_reset, pix_ready,
                     hist_acc_en, i);
         end
         @(negedge clk);
      end
      start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      pix_valid = 1'b0;
      #1;
      vectors++;
      if ({hist_clr_en, min_reset, pix_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL clear_exit: got clr/minrst/rdy=%b want 001",
                  {hist_clr_en, min_reset, pix_ready});
      end
   endtask

   // Accept stop_at pixels with ~50% valid; returns in the following cycle.
   task automatic test_accum(input int stop_at, input bit noisy,
                             input logic [HW-1:0] mh);
      int  acc;
      logic exp_rdy;
      acc       = 0;
      min_histo = mh;
      while (acc < stop_at) begin
         pix_valid = 1'($urandom_range(0, 1));
         start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         vectors++;
         if ({pix_ready, hist_acc_en, min_valid, pix_count, lut_identity, hist_clr_en}
             !== {1'b1, pix_valid, pix_valid, HW'(acc), 2'b00}) begin
            miscompares++;
            $display("FAIL accum_cycle: got rdy/acc/mv/cnt/id/clr=%b/%b/%b/%0d/%b/%b want 1/%b/%b/%0d/0/0",
                     pix_ready, hist_acc_en, min_valid, pix_count, lut_identity,
                     hist_clr_en, pix_valid, pix_valid, acc);
         end
         if (pix_valid) acc++;
         @(negedge clk);
      end
      pix_valid = 1'b1;
      start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      exp_rdy = (stop_at < N);
      vectors++;
      if ({pix_ready, hist_acc_en, pix_count} !== {exp_rdy, exp_rdy, HW'(stop_at)}) begin
         miscompares++;
         $display("FAIL accum_exit: got rdy/acc/cnt=%b/%b/%0d want %b/%b/%0d",
                  pix_ready, hist_acc_en, pix_count, exp_rdy, exp_rdy, stop_at);
      end
   endtask

   // CDF walk, LUT writes trailing by RdLat, single done 259 cycles after exit.
   task automatic test_cdf(input bit exp_id, input bit noisy);
      logic exp_rd;
      logic exp_wr;
      for (int k = 0; k < 256 + RL; k++) begin
         pix_valid = 1'b1;
         start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         exp_rd = (k < 256);
         exp_wr = (k >= RL);
         vectors++;
         if ({cdf_rd_en, cdf_rd_addr, cdf_acc_clr}
             !== {exp_rd, (exp_rd ? 8'(k) : 8'h00), (k == 0)}) begin
            miscompares++;
            $display("FAIL cdf_read %0d: got en/addr/clr=%b/%0d/%b want %b/%0d/%b",
                     k, cdf_rd_en, cdf_rd_addr, cdf_acc_clr, exp_rd,
                     (exp_rd ? k : 0), (k == 0));
         end
         vectors++;
         if (lut_wr_en !== exp_wr || (exp_wr && lut_wr_addr !== 8'(k - RL))) begin
            miscompares++;
            $display("FAIL lut_write %0d: got en/addr=%b/%0d want %b/%0d",
                     k, lut_wr_en, lut_wr_addr, exp_wr, k - RL);
         end
         vectors++;
         if ({pix_ready, hist_acc_en, done, busy, lut_identity} !== {4'b0001, exp_id}) begin
            miscompares++;
            $display("FAIL cdf_ctrl %0d: got rdy/acc/done/busy/id=%b want 0001%b",
                     k, {pix_ready, hist_acc_en, done, busy, lut_identity}, exp_id);
         end
         @(negedge clk);
      end
      start     = 1'b0;
      pix_valid = 1'b0;
      #1;
      vectors++;
      if ({done, busy, lut_wr_en, cdf_rd_en, lut_identity} !== {4'b1100, exp_id}) begin
         miscompares++;
         $display("FAIL done_cycle: got done/busy/wr/rd/id=%b want 1100%b",
                  {done, busy, lut_wr_en, cdf_rd_en, lut_identity}, exp_id);
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({done, busy, lut_identity, pix_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL back_to_idle: got done/busy/id/rdy=%b want 0000",
                  {done, busy, lut_identity, pix_ready});
      end
   endtask

   task automatic test_frame(input bit noisy, input logic [HW-1:0] mh, input bit exp_id);
      test_clear(noisy);
      test_accum(N, noisy, mh);
      test_cdf(exp_id, noisy);
   endtask

   // Non-flat frame: minimum count below frame size.
   task automatic test_normal_frame();
      test_frame(1'b0, HW'(10), 1'b0);
   endtask

   // Flat frame: minimum count equals frame size.
   task automatic test_flat_frame();
      test_frame(1'b0, HW'(N), 1'b1);
   endtask

   // Next frame starts in the IDLE cycle right after done.
   task automatic test_back_to_back();
      test_frame(1'b0, HW'(1), 1'b0);
   endtask

   // Random start pulses in CLEAR/ACCUM/CDF must not disturb the frame.
   task automatic test_start_ignored();
      test_frame(1'b1, HW'(3), 1'b0);
   endtask

   // Reset mid-ACCUM clears everything at once; next frame runs normally.
   task automatic test_abort();
      test_clear(1'b0);
      test_accum(N / 2, 1'b0, HW'(N));
      #1;
      reset = 1'b0;
      #1;
      vectors++;
      if (outs !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs: got %h want 0", outs);
      end
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      pix_valid = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({busy, done, pix_count} !== {2'b00, HW'(0)}) begin
         miscompares++;
         $display("FAIL abort_idle: got busy/done/cnt=%b/%b/%0d want 0/0/0",
                  busy, done, pix_count);
      end
      test_frame(1'b0, HW'(N), 1'b1);
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_flat_frame();
      test_back_to_back();
      test_start_ignored();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
